// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
package sipo_pkg;

    // One-entry output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Width of a counter that must represent 0..width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register; flags a dropped word when the
// consumer stalls while a new word arrives.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    buf_state_t state;

    // Buffer FSM with registered data and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUF_EMPTY;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                BUF_EMPTY: begin
                    // ready is meaningless with nothing to offer
                    if (load) begin
                        data  <= word;
                        state <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (ready) begin
                        if (load) begin
                            data <= word;
                        end else begin
                            state <= BUF_EMPTY;
                        end
                    end else if (load) begin
                        // keep the older word, drop the new one
                        overrun <= 1'b1;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

    assign valid = (state == BUF_FULL);

endmodule

// File: rtl/sipo_rx.sv
// MSB-first deserializer: shift register and bit counter with frame resync,
// feeding a one-entry output buffer.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serial_in,
    input  logic                      shift_en,
    input  logic                      frame_start,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          parallel_out,
    output logic                      out_valid,
    output logic                      overrun,
    output logic [cnt_w(WIDTH)-1:0]   bit_count
);

    localparam int unsigned CntW = cnt_w(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic             word_done;

    assign next_word = {shift_reg[WIDTH-2:0], serial_in};
    // frame_start always restarts the word, so it suppresses completion
    assign word_done = shift_en && !frame_start && (bit_count == LastBit);

    // Shift register and bit counter, with frame_start resync.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (frame_start) begin
            if (shift_en) begin
                shift_reg <= {{(WIDTH-1){1'b0}}, serial_in};
                bit_count <= CntW'(1);
            end else begin
                shift_reg <= '0;
                bit_count <= '0;
            end
        end else if (shift_en) begin
            shift_reg <= next_word;
            bit_count <= word_done ? '0 : bit_count + CntW'(1);
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (word_done),
        .word    (next_word),
        .ready   (out_ready),
        .data    (parallel_out),
        .valid   (out_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Directed plus randomized bench for sipo_rx against a queue-based model.
module tb_sipo_rx;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          shift_en;
    logic          frame_start;
    logic          out_ready;
    logic [W-1:0]  parallel_out;
    logic          out_valid;
    logic          overrun;
    logic [CW-1:0] bit_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         part[$];
    bit         m_valid;
    bit [W-1:0] m_word;
    bit         m_ovr;

    sipo_rx #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".parallel_out"}, 32'(parallel_out), 32'(m_word));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".bit_count"}, 32'(bit_count), 32'(part.size()));
    endtask

    // One clock with the given inputs; the model advances from the pre-edge state.
    task automatic step(input logic s, input logic en, input logic fs, input logic rdy);
        bit         done;
        bit [W-1:0] word;
        serial_in   = s;
        shift_en    = en;
        frame_start = fs;
        out_ready   = rdy;
        done  = 1'b0;
        word  = '0;
        m_ovr = 1'b0;
        if (fs) begin
            part.delete();
            if (en) part.push_back(s);
        end else if (en) begin
            part.push_back(s);
            if (part.size() == W) begin
                for (int i = 0; i < W; i++) word = {word[W-2:0], part[i]};
                done = 1'b1;
                part.delete();
            end
        end
        if (!m_valid) begin
            if (done) begin
                m_valid = 1'b1;
                m_word  = word;
            end
        end else if (rdy) begin
            if (done) m_word = word;
            else m_valid = 1'b0;
        end else if (done) begin
            m_ovr = 1'b1;
        end
        @(posedge clk);
        #1;
        check_model("step");
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        serial_in   = 1'b1;
        shift_en    = 1'b1;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        part.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_ovr   = 1'b0;
        @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;
    endtask

    // Send a word MSB first; rdy_last applies only to the completing strobe.
    task automatic send_word(input logic [W-1:0] w, input logic fs, input logic rdy,
                             input logic rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            step(w[i], 1'b1, fs && (i == W - 1), (i == 0) ? rdy_last : rdy);
        end
    endtask

    initial begin
        do_reset();
        do_reset();

        // Basic receive
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        check("a5_word", 32'(parallel_out), 32'hA5);
        check("a5_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_cleared", 32'(out_valid), 32'd0);

        // Back-to-back words with ready held high
        send_word(8'h3C, 1'b0, 1'b1, 1'b1);
        check("b2b_first", 32'(parallel_out), 32'h3C);
        send_word(8'hFF, 1'b0, 1'b1, 1'b1);
        check("b2b_second", 32'(parallel_out), 32'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure and overrun
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_kept", 32'(parallel_out), 32'h12);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_one_cycle", 32'(overrun), 32'd0);
        check("ovr_drained", 32'(out_valid), 32'd0);

        // Completion while full and accepted in the same cycle
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        send_word(8'hAA, 1'b0, 1'b0, 1'b1);
        check("swap_word", 32'(parallel_out), 32'hAA);
        check("swap_valid", 32'(out_valid), 32'd1);
        check("swap_no_ovr", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync after garbage bits
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send_word(8'hC3, 1'b1, 1'b1, 1'b1);
        check("resync_word", 32'(parallel_out), 32'hC3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("fs_no_shift", 32'(bit_count), 32'd0);

        // Reset mid-operation
        send_word(8'h99, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", 32'(bit_count), 32'd5);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        check("rst_word", 32'(parallel_out), 32'd0);
        check("rst_count", 32'(bit_count), 32'd0);
        send_word(8'h81, 1'b0, 1'b1, 1'b1);
        check("post_rst_word", 32'(parallel_out), 32'h81);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
